example1_and_gate: RTL and testbench

//  Registered bitwise AND of two DATA_WIDTH-bit operand buses.

---
 rtl/example1_and_gate.sv | 31 +++
 tb/tb_example1_and_gate.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/example1_and_gate.sv
// Registered bitwise AND of two operand buses: one combinational AND stage
// feeding a single output register, cleared asynchronously by an active-low reset.
module example1_and_gate #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  system_clock,
  input  logic                  system_rst_n,
  input  logic [DATA_WIDTH-1:0] first_data_in,
  input  logic [DATA_WIDTH-1:0] second_data_in,
  output logic [DATA_WIDTH-1:0] data_out_and_gate
);

  logic [DATA_WIDTH-1:0] and_d;
  logic [DATA_WIDTH-1:0] and_q;

  // There is no enable or handshake: a fresh result is captured on every edge.
  always_comb begin
    and_d = first_data_in & second_data_in;
  end

  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) begin
      and_q <= '0;
    end else begin
      and_q <= and_d;
    end
  end

  assign data_out_and_gate = and_q;

endmodule

// File: tb/tb_example1_and_gate.sv
// Self-checking bench for example1_and_gate: directed vector table, hand-written
// reset/hold/latency sequences, and randomized operands checked against a bit-level model.
module tb_example1_and_gate;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  example1_and_gate #(.DATA_WIDTH(W)) dut (
    .system_clock      (clk),
    .system_rst_n      (rst_n),
    .first_data_in     (a),
    .second_data_in    (b),
    .data_out_and_gate (y)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference: each result bit is 1 exactly when both operand bits are 1.
  function automatic logic [W-1:0] and_model(input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if ((int'(x[i]) + int'(z[i])) == 2) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb);
    a = va;
    b = vb;
  endtask

  task automatic edge_and_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra, rb, e;
    rst_n = 1'b1;
    a = '0;
    b = '0;

    // 1. async reset with no clock edge pending
    #1 rst_n = 1'b0;
    #1 check("async_reset", y, 8'h00);

    // 2. basic AND after reset release
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'b1101_0101, 8'b1010_1010);
    edge_and_sample();
    check("basic_and", y, 8'b1000_0000);
    @(negedge clk);
    check("basic_hold_mid", y, 8'b1000_0000);
    edge_and_sample();
    check("basic_recapture", y, 8'b1000_0000);

    // 3. directed table
    vecs.push_back('{8'hFF, 8'h5A, 8'h5A});
    vecs.push_back('{8'h00, 8'hFF, 8'h00});
    vecs.push_back('{8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{8'h81, 8'h01, 8'h01});
    vecs.push_back('{8'hC3, 8'h3C, 8'h00});
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b);
      edge_and_sample();
      check($sformatf("table_%0d", i), y, vecs[i].exp);
    end

    // 4. latency and hold: inputs change between edges
    @(negedge clk);
    drive(8'hF0, 8'h3C);
    #1 check("hold_before_edge", y, 8'h00);
    edge_and_sample();
    check("latency_one_edge", y, 8'h30);

    // 5. reset mid-run discards the held result
    #20 rst_n = 1'b0;
    #1 check("mid_reset_immediate", y, 8'h00);
    for (int k = 0; k < 2; k++) begin
      edge_and_sample();
      check($sformatf("reset_held_%0d", k), y, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hC3, 8'h81);
    #1 check("release_no_edge", y, 8'h00);
    edge_and_sample();
    check("first_edge_after_release", y, 8'h81);

    // reset coinciding with a clock edge: reset wins
    drive(8'hFF, 8'hFF);
    @(posedge clk);
    rst_n = 1'b0;
    #1 check("reset_at_edge", y, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 6. back-to-back pairs
    @(negedge clk);
    drive(8'hAA, 8'h0F);
    edge_and_sample();
    check("b2b_first", y, 8'h0A);
    @(negedge clk);
    drive(8'h55, 8'hF0);
    edge_and_sample();
    check("b2b_second", y, 8'h50);

    // randomized operands with occasional mid-cycle reset pulses
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        exp_q.delete();
        #5 check("rand_reset", y, 8'h00);
        #5 rst_n = 1'b1;
      end
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      drive(ra, rb);
      exp_q.push_back(and_model(ra, rb));
      edge_and_sample();
      e = exp_q.pop_front();
      check("rand_and", y, e);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
